// File: rtl/rob_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// rob_writeback_arbiter_if
// Bundles the requester-side handshake, the flush input and the three ROB
// writeback ports of rob_writeback_arbiter.
//   master : functional units + ROB side (drives requests and flush)
//   slave  : the arbiter (returns req_ready, wbN_* and busy)
// Packed request buses: requester i at [i*VREG_W +: VREG_W] / [i*DATA_W +: DATA_W].
// -----------------------------------------------------------------------------
interface rob_writeback_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int VREG_W  = 5,
  parameter int DATA_W  = 32
);
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*VREG_W-1:0] req_vregid;
  logic [NUM_REQ*DATA_W-1:0] req_val;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wb1_en;
  logic [VREG_W-1:0]         wb1_vregid;
  logic [DATA_W-1:0]         wb1_val;
  logic                      wb2_en;
  logic [VREG_W-1:0]         wb2_vregid;
  logic [DATA_W-1:0]         wb2_val;
  logic                      wb3_en;
  logic [VREG_W-1:0]         wb3_vregid;
  logic [DATA_W-1:0]         wb3_val;
  logic                      busy;

  modport master (
    output flush, req_valid, req_vregid, req_val,
    input  req_ready,
    input  wb1_en, wb1_vregid, wb1_val,
    input  wb2_en, wb2_vregid, wb2_val,
    input  wb3_en, wb3_vregid, wb3_val,
    input  busy
  );

  modport slave (
    input  flush, req_valid, req_vregid, req_val,
    output req_ready,
    output wb1_en, wb1_vregid, wb1_val,
    output wb2_en, wb2_vregid, wb2_val,
    output wb3_en, wb3_vregid, wb3_val,
    output busy
  );
endinterface

// File: rtl/rob_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rob_writeback_arbiter
// Shares the ROB's three result-writeback ports among NUM_REQ functional units.
// Each requester owns a one-entry holding slot. Every cycle up to three full
// slots are granted in round-robin order starting at rr_ptr and are written to
// the registered wb1/wb2/wb3 ports. flush empties every slot and suppresses
// the writebacks of that edge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rob_writeback_arbiter_if
//           flush, req_valid/req_vregid/req_val in; req_ready (combinational),
//           wbN_en/wbN_vregid/wbN_val (registered), busy (OR of slot state) out
// -----------------------------------------------------------------------------
module rob_writeback_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int VREG_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rob_writeback_arbiter_if.slave  bus
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_WB = 3;

  // Slot storage
  logic [NUM_REQ-1:0] full_r;
  logic [VREG_W-1:0]  vregid_r [NUM_REQ];
  logic [DATA_W-1:0]  val_r    [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr_r;

  // Registered writeback ports
  logic [NUM_WB-1:0]  wb_en_r;
  logic [VREG_W-1:0]  wb_vregid_r [NUM_WB];
  logic [DATA_W-1:0]  wb_val_r    [NUM_WB];

  // Arbitration results
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   sel_s [NUM_WB];
  logic [1:0]         grant_cnt_s;
  logic [PTR_W-1:0]   rr_ptr_nxt_s;
  logic [PTR_W-1:0]   scan_idx_s;
  int                 scan_pos_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] load_s;

  // Round-robin scan from rr_ptr: the first three full slots get ports 1..3 in
  // scan order; the pointer moves just past the last granted slot.
  always_comb begin
    grant_s      = '0;
    grant_cnt_s  = 2'd0;
    rr_ptr_nxt_s = rr_ptr_r;
    scan_idx_s   = '0;
    scan_pos_s   = 0;
    for (int p = 0; p < NUM_WB; p++) begin
      sel_s[p] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_pos_s = int'(rr_ptr_r) + k;
      if (scan_pos_s >= NUM_REQ) begin
        scan_pos_s = scan_pos_s - NUM_REQ;
      end else begin
        scan_pos_s = scan_pos_s;
      end
      scan_idx_s = PTR_W'(scan_pos_s);
      if (full_r[scan_idx_s] && (grant_cnt_s != 2'd3)) begin
        grant_s[scan_idx_s] = 1'b1;
        for (int p = 0; p < NUM_WB; p++) begin
          if (grant_cnt_s == 2'(p)) begin
            sel_s[p] = scan_idx_s;
          end else begin
            sel_s[p] = sel_s[p];
          end
        end
        grant_cnt_s = grant_cnt_s + 2'd1;
        if (scan_pos_s == NUM_REQ - 1) begin
          rr_ptr_nxt_s = '0;
        end else begin
          rr_ptr_nxt_s = PTR_W'(scan_pos_s + 1);
        end
      end else begin
        grant_cnt_s = grant_cnt_s;
      end
    end
  end

  // A granted slot empties at this edge, so it can take a new result at once.
  assign ready_s       = {NUM_REQ{~bus.flush}} & (~full_r | grant_s);
  assign load_s        = bus.req_valid & ready_s;
  assign bus.req_ready = ready_s;
  assign bus.busy      = |full_r;

  // Slot fill/drain; flush drops every pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        vregid_r[i] <= '0;
        val_r[i]    <= '0;
      end
    end else if (bus.flush) begin
      full_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load_s[i]) begin
          full_r[i]   <= 1'b1;
          vregid_r[i] <= bus.req_vregid[i*VREG_W +: VREG_W];
          val_r[i]    <= bus.req_val[i*DATA_W +: DATA_W];
        end else if (grant_s[i]) begin
          full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer; held across flush and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (bus.flush) begin
      rr_ptr_r <= rr_ptr_r;
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Writeback registers; unused ports keep their last index/value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_r <= '0;
      for (int p = 0; p < NUM_WB; p++) begin
        wb_vregid_r[p] <= '0;
        wb_val_r[p]    <= '0;
      end
    end else if (bus.flush) begin
      wb_en_r <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (2'(p) < grant_cnt_s) begin
          wb_en_r[p]     <= 1'b1;
          wb_vregid_r[p] <= vregid_r[sel_s[p]];
          wb_val_r[p]    <= val_r[sel_s[p]];
        end else begin
          wb_en_r[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.wb1_en     = wb_en_r[0];
  assign bus.wb1_vregid = wb_vregid_r[0];
  assign bus.wb1_val    = wb_val_r[0];
  assign bus.wb2_en     = wb_en_r[1];
  assign bus.wb2_vregid = wb_vregid_r[1];
  assign bus.wb2_val    = wb_val_r[1];
  assign bus.wb3_en     = wb_en_r[2];
  assign bus.wb3_vregid = wb_vregid_r[2];
  assign bus.wb3_val    = wb_val_r[2];

endmodule

// File: tb/tb_rob_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rob_writeback_arbiter
// Directed scenarios followed by randomized traffic. A reference model of the
// slots and round-robin pointer predicts req_ready/busy each cycle and the
// complete writeback-port state after each edge; predictions go into a queue
// that an independent monitor pops and compares 1 ns after every rising edge.
// -----------------------------------------------------------------------------
module tb_rob_writeback_arbiter;

  localparam int N  = 4;
  localparam int VW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [2:0]      en;
    logic [3*VW-1:0] vr;
    logic [3*DW-1:0] d;
  } wb_rec_t;

  logic clk;
  logic rst_n;

  rob_writeback_arbiter_if #(.NUM_REQ(N), .VREG_W(VW), .DATA_W(DW)) bus ();

  rob_writeback_arbiter #(.NUM_REQ(N), .VREG_W(VW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  wb_rec_t exp_q[$];

  // Reference model state
  logic            m_full [N];
  logic [VW-1:0]   m_vreg [N];
  logic [DW-1:0]   m_val  [N];
  int              m_rr;
  logic [2:0]      m_wb_en;
  logic [3*VW-1:0] m_wb_vr;
  logic [3*DW-1:0] m_wb_d;
  int              m_gidx [3];
  int              m_gn;
  logic [N-1:0]    m_grant;
  logic [N-1:0]    m_ready;

  // Stimulus staging
  logic [N-1:0]    st_v;
  logic [N*VW-1:0] st_vr;
  logic [N*DW-1:0] st_d;
  logic            st_fl;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0; m_vreg[i] = '0; m_val[i] = '0;
    end
    m_rr = 0; m_wb_en = '0; m_wb_vr = '0; m_wb_d = '0;
  endfunction

  // Occupied slots listed in round-robin order from m_rr; the first three win.
  function automatic void model_arbitrate();
    int order[$];
    order = {};
    for (int k = 0; k < N; k++) begin
      if (m_full[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
    end
    m_gn = (order.size() > 3) ? 3 : order.size();
    m_grant = '0;
    for (int p = 0; p < m_gn; p++) begin
      m_gidx[p] = order[p];
      m_grant[order[p]] = 1'b1;
    end
  endfunction

  task automatic put(input int i, input logic [VW-1:0] vr, input logic [DW-1:0] d);
    st_v[i] = 1'b1;
    st_vr[i*VW +: VW] = vr;
    st_d[i*DW +: DW] = d;
  endtask

  task automatic clr();
    st_v = '0; st_fl = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic do_cycle();
    logic [N-1:0] exp_rdy;
    bus.req_valid  = st_v;
    bus.req_vregid = st_vr;
    bus.req_val    = st_d;
    bus.flush      = st_fl;
    #1;
    model_arbitrate();
    for (int i = 0; i < N; i++) exp_rdy[i] = !st_fl && (!m_full[i] || m_grant[i]);
    m_ready = exp_rdy;
    n_cmp++;
    if (bus.req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, exp_rdy);
    end
    n_cmp++;
    if (bus.busy !== (m_full.or())) begin
      n_fail++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, bus.busy, m_full.or());
    end
    @(posedge clk);
    if (st_fl) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_wb_en = '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (p < m_gn) begin
          m_wb_en[p] = 1'b1;
          m_wb_vr[p*VW +: VW] = m_vreg[m_gidx[p]];
          m_wb_d[p*DW +: DW]  = m_val[m_gidx[p]];
        end else begin
          m_wb_en[p] = 1'b0;
        end
      end
      if (m_gn > 0) m_rr = (m_gidx[m_gn-1] + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (st_v[i] && exp_rdy[i]) begin
          m_full[i] = 1'b1;
          m_vreg[i] = st_vr[i*VW +: VW];
          m_val[i]  = st_d[i*DW +: DW];
        end else if (m_grant[i]) begin
          m_full[i] = 1'b0;
        end
      end
    end
    exp_q.push_back('{en: m_wb_en, vr: m_wb_vr, d: m_wb_d});
    mon_on = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: compares the full writeback-port state after every edge.
  initial begin
    wb_rec_t e;
    wb_rec_t g;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        g = '{en: {bus.wb3_en, bus.wb2_en, bus.wb1_en},
              vr: {bus.wb3_vregid, bus.wb2_vregid, bus.wb1_vregid},
              d:  {bus.wb3_val, bus.wb2_val, bus.wb1_val}};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected t=%0t got_en=%b exp=none", $time, g.en);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++;
            $display("FAIL wb_ports t=%0t got en=%b vr=%h d=%h exp en=%b vr=%h d=%h",
                     $time, g.en, g.vr, g.d, e.en, e.vr, e.d);
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if ({bus.wb1_en, bus.wb2_en, bus.wb3_en, bus.busy} !== 4'b0000 ||
        {bus.wb1_vregid, bus.wb2_vregid, bus.wb3_vregid} !== '0 ||
        {bus.wb1_val, bus.wb2_val, bus.wb3_val} !== '0) begin
      n_fail++;
      $display("FAIL %s t=%0t got en=%b%b%b busy=%b vr=%h/%h/%h val=%h/%h/%h exp all zero",
               tag, $time, bus.wb1_en, bus.wb2_en, bus.wb3_en, bus.busy,
               bus.wb1_vregid, bus.wb2_vregid, bus.wb3_vregid,
               bus.wb1_val, bus.wb2_val, bus.wb3_val);
    end
    n_cmp++;
    if (bus.req_ready !== {N{1'b1}}) begin
      n_fail++;
      $display("FAIL %s_ready t=%0t got=%b exp=%b", tag, $time, bus.req_ready, {N{1'b1}});
    end
  endtask

  // Stimulus
  initial begin
    logic          pend  [N];
    logic [VW-1:0] pvr   [N];
    logic [DW-1:0] pd    [N];
    rst_n = 1'b0;
    st_v = '0; st_vr = '0; st_d = '0; st_fl = 1'b0;
    bus.req_valid = '0; bus.req_vregid = '0; bus.req_val = '0; bus.flush = 1'b0;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single result on slot 0, then drain
    clr(); put(0, 5'd5, 32'hDEADBEEF); do_cycle();
    clr(); repeat (3) do_cycle();

    // Four-way contention
    clr(); put(0, 5'd1, 32'h11); put(1, 5'd2, 32'h22); put(2, 5'd3, 32'h33); put(3, 5'd4, 32'h44);
    do_cycle();
    clr(); repeat (3) do_cycle();

    // Rotation: slot 1 granted moves the pointer to 2 while 0,1,3 reload
    clr(); put(1, 5'd7, 32'h77); do_cycle();
    clr(); put(0, 5'd20, 32'hA0); put(1, 5'd21, 32'hA1); put(3, 5'd23, 32'hA3); do_cycle();
    clr(); repeat (2) do_cycle();

    // Back-to-back streaming on requester 1
    for (int k = 0; k < 3; k++) begin
      clr(); put(1, 5'(10 + k), 32'h1000 + 32'(k)); do_cycle();
    end
    clr(); repeat (2) do_cycle();

    // Flush with slots 0 and 2 full and a new request on 1
    clr(); put(0, 5'd8, 32'h88); put(2, 5'd9, 32'h99); do_cycle();
    clr(); put(1, 5'd6, 32'h66); st_fl = 1'b1; do_cycle();
    clr(); repeat (2) do_cycle();

    // Asynchronous reset with three slots full and wb1 active
    clr(); put(0, 5'd24, 32'hC0); put(1, 5'd25, 32'hC1); put(3, 5'd27, 32'hC3); do_cycle();
    do_cycle();
    n_cmp++;
    if (bus.wb1_en !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset t=%0t got wb1_en=%b busy=%b exp 1 1", $time, bus.wb1_en, bus.busy);
    end
    #2;
    clr();
    bus.req_valid = '0;
    rst_n = 1'b0;
    mon_on = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr(); put(2, 5'd30, 32'hFACE); do_cycle();
    clr(); repeat (2) do_cycle();

    // Randomized traffic; requesters hold their result until accepted
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      clr();
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
          pend[i] = 1'b1;
          pvr[i]  = 5'($urandom);
          pd[i]   = $urandom;
        end
        if (pend[i]) put(i, pvr[i], pd[i]);
      end
      st_fl = ($urandom_range(0, 29) == 0);
      do_cycle();
      for (int i = 0; i < N; i++) begin
        if (st_fl || (pend[i] && m_ready[i])) pend[i] = 1'b0;
      end
    end
    clr(); repeat (3) do_cycle();

    mon_on = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_writeback_arbiter.md
Name: rob_writeback_arbiter

Overview:
Shares the reorder buffer's three result-writeback ports among NUM_REQ functional-unit requesters (ALU, load/store buffer, branch unit, ...).
- Each requester owns a one-entry holding slot with a valid/ready handshake.
- Each cycle, up to three full slots are granted in round-robin order and driven onto registered wb1/wb2/wb3 outputs.
- A flush input, fed by the ROB's mispredict reset, discards everything in flight.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
VREG_W, 5, ROB entry index width
DATA_W, 32, result value width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  ROB mispredict reset; drop all pending results
req_valid  input  NUM_REQ  requester i presents a result
req_vregid  input  NUM_REQ*VREG_W  ROB index, requester i at bits [i*VREG_W +: VREG_W]
req_val  input  NUM_REQ*DATA_W  result value, requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  slot i can accept this cycle (combinational)
wb1_en  output  1  writeback port 1 valid
wb1_vregid  output  VREG_W  port 1 ROB index
wb1_val  output  DATA_W  port 1 value
wb2_en / wb2_vregid / wb2_val  output  1 / VREG_W / DATA_W  port 2
wb3_en / wb3_vregid / wb3_val  output  1 / VREG_W / DATA_W  port 3
busy  output  1  any slot full (registered state, combinational OR)

Behaviour:
- Reset (rst_n low, asynchronous):
  - all slots empty; rr_ptr = 0.
  - wbN_en = 0, wbN_vregid = 0, wbN_val = 0; busy = 0.
- State per slot i: full_i, vregid_i, val_i. Global state: rr_ptr (0..NUM_REQ-1).
- Arbitration (combinational on current slot state):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first full slot found gets port 1, the second port 2, the third port 3.
  - At most 3 grants per cycle.
- req_ready[i] = !flush && (!full_i || granted_i). A slot may be granted and refilled on the same edge, so one result per cycle per requester is sustained.
- Rising edge, no flush:
  - granted slot i: drives wbK_en = 1, wbK_vregid = vregid_i, wbK_val = val_i (K = its grant rank); full_i cleared unless refilled.
  - unused ports: wbK_en = 0; vregid/val keep their last value.
  - req_valid[i] && req_ready[i]: slot i loaded, full_i = 1.
  - rr_ptr: if any grant, (index of last granted slot + 1) mod NUM_REQ; otherwise unchanged.
- Latency: a result accepted at edge E is sampled by the arbiter in cycle E..E+1 and appears on wbK at edge E+1 at the earliest. The ROB captures it at edge E+2.
- Contention: more than 3 full slots leaves the non-granted ones full. They hold their contents and req_ready stays 0 until granted.
- Fairness: any full slot is granted within ceil(NUM_REQ/3) cycles.
- Flush, sampled at the edge:
  - all slots cleared; no input accepted; all wbN_en = 0 on that edge; rr_ptr unchanged.
  - results presented during the flush cycle are lost. Requesters observe req_ready = 0 and must drop them, since they flush on the same signal.
- Asynchronous reset mid-operation aborts everything immediately to reset values.
- Duplicate vregid in different slots is not checked; the issue logic guarantees uniqueness.
- req_valid with req_ready = 0: the requester must hold vregid/val stable until accepted.

Test Plan:
1. Single result: after reset, req_valid[0] = 1 with vregid = 5, val = 0xDEADBEEF for one cycle -> req_ready[0] = 1. At the next edge slot 0 is full; one edge later wb1_en = 1, wb1_vregid = 5, wb1_val = 0xDEADBEEF; wb2_en = wb3_en = 0; then all wb*_en = 0 and busy = 0.
2. Four-way contention: slots 0..3 all full (vregid 1..4), rr_ptr = 0 -> first grant cycle: wb1/2/3 = vregid 1/2/3 and rr_ptr = 3. Next cycle: wb1 = vregid 4, rr_ptr = 0.
3. Round-robin rotation: rr_ptr = 2, slots 0, 1 and 3 full -> port 1 = slot 3, port 2 = slot 0, port 3 = slot 1; new rr_ptr = 2.
4. Back-to-back streaming: requester 1 presents vregid 10, 11, 12 on consecutive cycles with no other traffic -> req_ready[1] stays 1 throughout; wb1 shows 10, 11, 12 on three consecutive edges.
5. Flush: slots 0 and 2 full, flush = 1 for one cycle while req_valid[1] = 1 -> req_ready all 0; next edge all wb*_en = 0 and busy = 0. The following cycle with no requests produces no writeback.
6. Asynchronous reset: assert rst_n = 0 mid-cycle while wb1_en = 1 and 3 slots are full -> outputs go to 0 without waiting for clk. After release, a request on slot 2 is granted with rr_ptr starting from 0.
